controle_jogo_matriz: RTL and testbench
=======================================

Name: controle_jogo_matriz

Overview:
Game control unit for the LED-matrix puzzle. Conditions the 8 raw push-buttons into single-cycle, one-at-a-time toggle pulses for the matrix controller. Sequences levels 0..NUM_NIVEIS-1: it clears the matrix, counts moves, detects level completion and drives victory/defeat. It sits between the board I/O and the matrix block, sourcing that block's botoes, nivel and reset inputs and consuming its nivel_concluido.

Parameters:
NUM_NIVEIS, 5, number of levels; final level index is NUM_NIVEIS-1 (max 8).
DEBOUNCE_CYC, 16, cycles a synchronized button must stay stable before its level is accepted.
CELEB_CYC, 32, cycles spent in CELEBRA after a level is completed.
MAX_JOGADAS, 63, move limit per level; reaching it without completion means defeat (must fit in 6 bits).

Ports:
clk  in  1  system clock
rst  in  1  asynchronous, active-high reset
iniciar  in  1  start/restart request; synchronous, level-sampled
botoes_in  in  8  raw, asynchronous, active-high buttons
nivel_concluido  in  1  registered completion flag from the matrix controller
botoes_out  out  8  one-hot or zero toggle pulse to the matrix controller
rst_matriz  out  1  one-cycle clear pulse to the matrix controller's reset input
nivel  out  3  current level index
jogadas  out  6  moves taken in the current level
estado  out  3  FSM state code, for debug/display
vitoria  out  1  high while in VITORIA
derrota  out  1  high while in DERROTA

Behaviour:
- Reset values: state OCIOSO; all outputs 0; pending, debounce and settle registers 0. rst takes effect immediately at any time, including mid-level or mid-celebration.
- Button path, per bit: 2-flop synchronizer, then debouncer.
  - The debounced level changes only after DEBOUNCE_CYC consecutive stable cycles.
  - A debounced rising edge sets the bit's pending flag.
  - Holding a button produces exactly one press.
  - A release followed by a re-press produces a new press.
- Grant logic, active only in JOGANDO with settle==0:
  - Each cycle, the lowest-index pending bit is granted.
  - The granted bit is driven on botoes_out for exactly 1 cycle (registered output) and its pending flag is cleared.
  - At most one grant per cycle; other pending bits wait for later cycles.
  - Outside JOGANDO, all pending flags are cleared every cycle and botoes_out=0.
- Each grant increments jogadas by 1, saturating at MAX_JOGADAS.
- Each grant also loads settle=2. settle decrements to 0 and covers the matrix's toggle-then-compare latency.
- FSM states (estado code):
  - OCIOSO (0): nivel=0. iniciar=1 moves to LIMPA.
  - LIMPA (1):
    - rst_matriz=1 for this single cycle; jogadas cleared.
    - settle loaded with 2, so stale nivel_concluido is ignored.
    - Next cycle: JOGANDO.
  - JOGANDO (2), evaluated only when settle==0 and no grant is issued this cycle:
    - nivel_concluido=1 moves to CELEBRA. Completion takes priority over the move limit when both hold.
    - Otherwise, jogadas==MAX_JOGADAS moves to DERROTA.
  - CELEBRA (3):
    - A counter runs CELEB_CYC cycles.
    - At terminal count: if nivel==NUM_NIVEIS-1, go to VITORIA; else nivel+1 and go to LIMPA.
    - Buttons are ignored.
  - VITORIA (4): vitoria=1; hold. iniciar moves to LIMPA with nivel=0.
  - DERROTA (5): derrota=1; hold. iniciar moves to LIMPA with nivel unchanged (retry the same level).
- iniciar is ignored in LIMPA, JOGANDO and CELEBRA.
- nivel updates in the same cycle as the CELEBRA to LIMPA transition.

Decomposition:
- Shared package jogo_pkg holds:
  - state encoding constants: OCIOSO..DERROTA, 3-bit;
  - the N_BOTOES=8 constant;
  - the level-index width (3).
- Natural sub-module: debounce_botao (synchronizer + stability counter + rising-edge pulse). It is instantiated 8 times via generate.

Test Plan:
- Reset, then iniciar=1 for 1 cycle -> exactly 1 cycle of rst_matriz=1, estado goes 0,1,2, nivel=0, jogadas=0, botoes_out=0 throughout.
- In JOGANDO, hold botoes_in[3] for 200 cycles -> exactly one botoes_out=8'b0000_1000 pulse, DEBOUNCE_CYC+3 cycles after assertion; jogadas=1.
- Press bits 5 and 1 in the same cycle -> botoes_out=8'b0000_0010 in one cycle, then 8'b0010_0000 in the next grant-eligible cycle; jogadas=2.
- Model completion: raise nivel_concluido 2 cycles after a grant at nivel=0 -> CELEBRA for 32 cycles, then LIMPA with nivel=1 and rst_matriz pulse. Repeat through nivel=4 -> vitoria=1, estado=4.
- With MAX_JOGADAS=3, issue 3 presses and no completion -> derrota=1, estado=5. Then iniciar -> LIMPA with nivel unchanged and jogadas=0.
- Assert rst during CELEBRA at nivel=2 -> next cycle estado=0, nivel=0, all outputs 0; pending presses discarded.

Source files
------------

// File: rtl/jogo_pkg.sv
// jogo_pkg: shared constants and state encoding for the LED-matrix game control
package jogo_pkg;
  localparam int N_BOTOES = 8;
  localparam int NV_W = 3;
  typedef enum logic [2:0] {
    OCIOSO  = 3'd0,
    LIMPA   = 3'd1,
    JOGANDO = 3'd2,
    CELEBRA = 3'd3,
    VITORIA = 3'd4,
    DERROTA = 3'd5
  } estado_t;
endpackage

// File: rtl/debounce_botao.sv
// debounce_botao: 2-flop synchronizer, stability counter and debounced rising-edge pulse
module debounce_botao #(
  parameter int DEBOUNCE_CYC = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic botao,
  output logic pulso
);
  localparam int W = $clog2(DEBOUNCE_CYC + 1);
  logic s1, s2, estavel, aceita;
  logic [W-1:0] cnt;
  assign aceita = (s2 != estavel) && (cnt == W'(DEBOUNCE_CYC - 1));
  assign pulso = aceita && s2;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      estavel <= 1'b0;
      cnt <= '0;
    end else begin
      s1 <= botao;
      s2 <= s1;
      cnt <= (s2 == estavel || aceita) ? '0 : cnt + W'(1);
      if (aceita) estavel <= s2;
    end
endmodule

// File: rtl/controle_jogo_matriz.sv
// controle_jogo_matriz: conditions buttons into one-hot toggle pulses and sequences game levels
module controle_jogo_matriz
  import jogo_pkg::*;
#(
  parameter int NUM_NIVEIS   = 5,
  parameter int DEBOUNCE_CYC = 16,
  parameter int CELEB_CYC    = 32,
  parameter int MAX_JOGADAS  = 63
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                iniciar,
  input  logic [N_BOTOES-1:0] botoes_in,
  input  logic                nivel_concluido,
  output logic [N_BOTOES-1:0] botoes_out,
  output logic                rst_matriz,
  output logic [NV_W-1:0]     nivel,
  output logic [5:0]          jogadas,
  output logic [2:0]          estado,
  output logic                vitoria,
  output logic                derrota
);
  localparam int CW = $clog2(CELEB_CYC + 1);
  localparam logic [5:0] MAX = 6'(MAX_JOGADAS);
  estado_t st;
  logic [N_BOTOES-1:0] rise, pend, grant;
  logic [1:0] settle;
  logic [CW-1:0] celeb;
  logic elig, livre, celeb_done, ultimo, restart, enter_limpa;
  for (genvar i = 0; i < N_BOTOES; i++) begin : g_db
    debounce_botao #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_db (
      .clk(clk), .rst(rst), .botao(botoes_in[i]), .pulso(rise[i])
    );
  end
  assign estado = st;
  assign elig = (st == JOGANDO) && (settle == 2'd0);
  assign grant = elig ? (pend & (-pend)) : '0;
  assign livre = elig && (pend == '0);
  assign celeb_done = (st == CELEBRA) && (celeb == CW'(CELEB_CYC - 1));
  assign ultimo = nivel == NV_W'(NUM_NIVEIS - 1);
  assign restart = iniciar && (st == OCIOSO || st == VITORIA || st == DERROTA);
  assign enter_limpa = restart || (celeb_done && !ultimo);
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      st <= OCIOSO;
      pend <= '0;
      botoes_out <= '0;
      rst_matriz <= 1'b0;
      settle <= 2'd0;
      celeb <= '0;
      nivel <= '0;
      jogadas <= '0;
      vitoria <= 1'b0;
      derrota <= 1'b0;
    end else begin
      botoes_out <= grant;
      pend <= (st == JOGANDO) ? ((pend & ~grant) | rise) : '0;
      rst_matriz <= enter_limpa;
      settle <= (enter_limpa || grant != '0) ? 2'd2 : (st == JOGANDO && settle != 2'd0) ? settle - 2'd1 : settle;
      jogadas <= enter_limpa ? '0 : (grant != '0 && jogadas != MAX) ? jogadas + 6'd1 : jogadas;
      celeb <= (st == CELEBRA) ? celeb + CW'(1) : '0;
      if (st == VITORIA && iniciar) nivel <= '0;
      else if (celeb_done && !ultimo) nivel <= nivel + NV_W'(1);
      vitoria <= (st == VITORIA) ? !iniciar : (celeb_done && ultimo);
      derrota <= (st == DERROTA) ? !iniciar : (livre && !nivel_concluido && jogadas == MAX);
      case (st)
        OCIOSO, VITORIA, DERROTA: if (iniciar) st <= LIMPA;
        LIMPA: st <= JOGANDO;
        JOGANDO: if (livre) st <= nivel_concluido ? CELEBRA : (jogadas == MAX) ? DERROTA : JOGANDO;
        CELEBRA: if (celeb_done) st <= ultimo ? VITORIA : LIMPA;
        default: st <= OCIOSO;
      endcase
    end
endmodule

// File: tb/tb_controle_jogo_matriz.sv
// tb_controle_jogo_matriz: directed checks of button conditioning and level sequencing
module tb_controle_jogo_matriz;
  logic clk = 1'b0;
  logic rst, iniciar, nivel_concluido;
  logic [7:0] botoes_in, botoes_out;
  logic rst_matriz, vitoria, derrota;
  logic [2:0] nivel, estado;
  logic [5:0] jogadas;
  int n_vec = 0;
  int n_err = 0;
  controle_jogo_matriz #(
    .NUM_NIVEIS(5), .DEBOUNCE_CYC(16), .CELEB_CYC(32), .MAX_JOGADAS(3)
  ) dut (
    .clk(clk), .rst(rst), .iniciar(iniciar), .botoes_in(botoes_in),
    .nivel_concluido(nivel_concluido), .botoes_out(botoes_out),
    .rst_matriz(rst_matriz), .nivel(nivel), .jogadas(jogadas),
    .estado(estado), .vitoria(vitoria), .derrota(derrota)
  );
  always #5 clk = ~clk;
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic chk_idle(input string tag);
    chk({tag, "_estado"}, estado, 0);
    chk({tag, "_outs"}, {botoes_out, rst_matriz, nivel, jogadas, vitoria, derrota}, 0);
  endtask
  task automatic play_level(input logic [7:0] mask, input logic [7:0] first, input logic [5:0] jog);
    int np, k;
    logic [7:0] got;
    np = 0; k = 0; got = 8'h00;
    botoes_in = mask;
    while (np < $countones(mask) && k < 150) begin
      tick();
      k++;
      if (botoes_out != 8'h00) begin
        if (np == 0) got = botoes_out;
        np++;
      end
    end
    chk("grant_count", np, $countones(mask));
    chk("first_grant", got, first);
    tick();
    tick();
    chk("pre_celebra", estado, 2);
    nivel_concluido = 1'b1;
    tick();
    chk("to_celebra", estado, 3);
    chk("jogadas_lvl", jogadas, jog);
    nivel_concluido = 1'b0;
    botoes_in = 8'h00;
  endtask
  task automatic celebrate(input int lvl);
    int c;
    logic quiet;
    c = 1; quiet = 1'b1;
    while (c < 100) begin
      tick();
      if (estado != 3'd3) break;
      c++;
      quiet &= (botoes_out == 8'h00);
    end
    chk("celeb_len", c, 32);
    chk("celeb_quiet", quiet, 1);
    if (lvl < 4) begin
      chk("next_limpa", estado, 1);
      chk("next_nivel", nivel, lvl + 1);
      chk("next_rstm", rst_matriz, 1);
      tick();
      chk("next_jogando", estado, 2);
    end else begin
      chk("vit_estado", estado, 4);
      chk("vit_flag", vitoria, 1);
      chk("vit_nivel", nivel, 4);
    end
  endtask
  initial begin
    int np, kp, kd;
    logic [7:0] seq [2];
    rst = 1'b1; iniciar = 1'b0; nivel_concluido = 1'b0; botoes_in = 8'h00;
    tick();
    tick();
    chk_idle("reset");
    rst = 1'b0;
    tick();
    chk_idle("idle");
    iniciar = 1'b1;
    tick();
    iniciar = 1'b0;
    chk("start_limpa", estado, 1);
    chk("start_rstm", rst_matriz, 1);
    chk("start_bo", botoes_out, 0);
    tick();
    chk("start_jogando", estado, 2);
    chk("start_rstm_off", rst_matriz, 0);
    chk("start_nj", {nivel, jogadas}, 0);
    iniciar = 1'b1;
    tick();
    iniciar = 1'b0;
    chk("ign_iniciar", {estado, rst_matriz}, {3'd2, 1'b0});
    botoes_in = 8'h08;
    np = 0; kp = 0;
    for (int k = 1; k <= 200; k++) begin
      tick();
      if (botoes_out != 8'h00) begin
        np++;
        if (np == 1) begin kp = k; chk("hold_val", botoes_out, 8'h08); end
      end
    end
    chk("hold_count", np, 1);
    chk("hold_lat", kp, 19);
    chk("hold_jog", jogadas, 1);
    botoes_in = 8'h00;
    np = 0;
    for (int k = 0; k < 25; k++) begin
      tick();
      if (botoes_out != 8'h00) np++;
    end
    chk("release_quiet", np, 0);
    botoes_in = 8'h22;
    np = 0; kd = 0;
    seq[0] = 8'h00; seq[1] = 8'h00;
    for (int k = 1; k <= 40; k++) begin
      tick();
      if (botoes_out != 8'h00) begin
        if (np < 2) seq[np] = botoes_out;
        np++;
        if (np == 1) chk("pair_k1", k, 19);
        if (np == 2) chk("pair_k2", k, 22);
      end
      if (derrota && kd == 0) kd = k;
    end
    chk("pair_count", np, 2);
    chk("pair_first", seq[0], 8'h02);
    chk("pair_second", seq[1], 8'h20);
    chk("der_when", kd, 25);
    chk("der_state", {estado, derrota, jogadas}, {3'd5, 1'b1, 6'd3});
    botoes_in = 8'h00;
    for (int k = 0; k < 25; k++) tick();
    chk("der_hold", {estado, derrota}, {3'd5, 1'b1});
    iniciar = 1'b1;
    tick();
    iniciar = 1'b0;
    chk("retry_limpa", {estado, rst_matriz, nivel, jogadas, derrota}, {3'd1, 1'b1, 3'd0, 6'd0, 1'b0});
    tick();
    chk("retry_jogando", estado, 2);
    for (int l = 0; l < 2; l++) begin
      play_level(8'h01, 8'h01, 6'd1);
      celebrate(l);
    end
    play_level(8'h01, 8'h01, 6'd1);
    for (int k = 0; k < 10; k++) tick();
    chk("mid_celeb", {estado, nivel}, {3'd3, 3'd2});
    botoes_in = 8'h40;
    rst = 1'b1;
    #1;
    chk_idle("async_rst");
    tick();
    rst = 1'b0;
    tick();
    chk_idle("post_rst");
    for (int k = 0; k < 25; k++) tick();
    iniciar = 1'b1;
    tick();
    iniciar = 1'b0;
    np = 0;
    for (int k = 0; k < 30; k++) begin
      tick();
      if (botoes_out != 8'h00) np++;
    end
    chk("discard_pend", np, 0);
    botoes_in = 8'h00;
    for (int k = 0; k < 25; k++) tick();
    for (int l = 0; l < 4; l++) begin
      play_level(8'h01, 8'h01, 6'd1);
      celebrate(l);
    end
    play_level(8'h17, 8'h01, 6'd3);
    celebrate(4);
    tick();
    chk("vit_hold", {estado, vitoria}, {3'd4, 1'b1});
    iniciar = 1'b1;
    tick();
    iniciar = 1'b0;
    chk("vit_restart", {estado, rst_matriz, nivel, jogadas, vitoria}, {3'd1, 1'b1, 3'd0, 6'd0, 1'b0});
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
